cordic_cos: RTL and testbench

Iterative CORDIC (rotation mode) cosine stage. Consumes the signed 24-bit fixed-point angle produced by the float-to-fixed converter (range [-1, 1) radians, 22 fractional bits) and returns cos(θ) in the same fixed format. It sits directly downstream of the converter inside the Nios II multi-cycle custom instruction, and uses the custom-instruction start/done handshake.

---
 rtl/cordic_pkg.sv | 48 ++++
 rtl/cordic_cos_stage.sv | 34 +++
 rtl/cordic_cos.sv | 128 ++++++++++++
 tb/tb_cordic_cos.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared fixed-point constants, CORDIC gain/arctangent table generators and FSM states.
// Table values are built from 2^-40 scaled integers so they elaborate as constants.
package cordic_pkg;

  localparam int FRAC_BITS = 22;
  localparam int DATA_W    = 24;

  localparam int     TAB_S   = 40;
  localparam longint K_S40   = 64'sd667681663034;   // 0.6072529350 * 2^40
  localparam longint PI4_S40 = 64'sd863554413089;   // atan(1) * 2^40

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic longint round_s40(input longint v, input int guard);
    int sh;
    sh = TAB_S - FRAC_BITS - guard;
    return (v + (64'sd1 <<< (sh - 32'sd1))) >>> sh;
  endfunction

  function automatic longint k_const(input int guard);
    return round_s40(K_S40, guard);
  endfunction

  // atan(2^-idx) by its Taylor series; idx >= 1 keeps the argument <= 0.5.
  function automatic longint atan_lut(input int idx, input int guard);
    longint acc;
    longint term;
    int     sh;
    acc = 64'sd0;
    if (idx == 32'sd0) begin
      acc = PI4_S40;
    end else begin
      for (int n = 0; n < 24; n++) begin
        sh = idx * (32'sd2 * n + 32'sd1);
        if (sh <= TAB_S) term = (64'sd1 <<< (TAB_S - sh)) / longint'(32'sd2 * n + 32'sd1);
        else             term = 64'sd0;
        if ((n % 32'sd2) == 32'sd1) acc = acc - term;
        else                        acc = acc + term;
      end
    end
    return round_s40(acc, guard);
  endfunction

endpackage

// File: rtl/cordic_cos_stage.sv
// One combinational CORDIC rotation-mode micro-rotation.
module cordic_stage #(
  parameter int W  = 26,
  parameter int CW = 4
) (
  input  logic [W-1:0]  x_in,
  input  logic [W-1:0]  y_in,
  input  logic [W-1:0]  z_in,
  input  logic [CW-1:0] iter,
  input  logic [W-1:0]  lut,
  output logic [W-1:0]  x_out,
  output logic [W-1:0]  y_out,
  output logic [W-1:0]  z_out
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  // Rotate towards z = 0; a non-negative residual angle rotates positively.
  always_comb begin
    x_sh = $signed(x_in) >>> iter;
    y_sh = $signed(y_in) >>> iter;
    if (!z_in[W-1]) begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - lut;
    end else begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + lut;
    end
  end

endmodule

// File: rtl/cordic_cos.sv
// Iterative CORDIC cosine with start/done handshake, one micro-rotation per enabled clock.
// Optional sin_out port is enabled by defining CORDIC_SIN_EN.
module cordic_cos
  import cordic_pkg::*;
#(
  parameter int ITERS = 16,
  parameter int GUARD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [DATA_W-1:0] angle,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
`ifdef CORDIC_SIN_EN
  ,
  output logic [DATA_W-1:0] sin_out
`endif
);

  localparam int W  = DATA_W + GUARD;
  localparam int CW = $clog2(ITERS);

  localparam logic [W-1:0]        K_INIT    = W'(k_const(GUARD));
  localparam logic signed [W-1:0] ONE_W     = W'(64'sd4194304);
  localparam logic signed [W-1:0] ONE_NEG_W = -ONE_W;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [W-1:0]  z;
  logic [CW-1:0] iter;
  logic [W-1:0]  x_n;
  logic [W-1:0]  y_n;
  logic [W-1:0]  z_n;
  logic [W-1:0]  lut_tab [ITERS];
  logic          last_iter;

  for (genvar g = 0; g < ITERS; g++) begin : g_lut
    assign lut_tab[g] = W'(atan_lut(g, GUARD));
  end

  assign last_iter = (iter == CW'(ITERS - 1));

  cordic_stage #(.W(W), .CW(CW)) u_stage (
    .x_in  (x),
    .y_in  (y),
    .z_in  (z),
    .iter  (iter),
    .lut   (lut_tab[iter]),
    .x_out (x_n),
    .y_out (y_n),
    .z_out (z_n)
  );

  // Drop guard bits and clamp to +1.0 (and -1.0 when both is set).
  function automatic logic [DATA_W-1:0] clamp_out(input logic [W-1:0] v, input logic both);
    logic signed [W-1:0] t;
    t = $signed(v) >>> GUARD;
    if (t > ONE_W)                   return DATA_W'(24'h400000);
    else if (both && (t < ONE_NEG_W)) return DATA_W'(24'hC00000);
    else                             return t[DATA_W-1:0];
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)       state <= ST_IDLE;
    else if (clk_en) state <= state_next;
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;  else state_next = ST_IDLE;
      ST_RUN:  if (last_iter) state_next = ST_DONE; else state_next = ST_RUN;
      ST_DONE: if (start) state_next = ST_RUN;  else state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      z      <= '0;
      iter   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef CORDIC_SIN_EN
      sin_out <= '0;
`endif
    end else if (clk_en) begin
      case (state)
        ST_RUN: begin
          x    <= x_n;
          y    <= y_n;
          z    <= z_n;
          iter <= iter + CW'(1'b1);
          if (last_iter) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= clamp_out(x_n, 1'b0);
`ifdef CORDIC_SIN_EN
            sin_out <= clamp_out(y_n, 1'b1);
`endif
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            x    <= K_INIT;
            y    <= '0;
            z    <= {angle, {GUARD{1'b0}}};
            iter <= '0;
            busy <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cos.sv
// Self-checking bench for cordic_cos: real-arithmetic CORDIC model, scoreboard queue, directed and random cases.
module tb_cordic_cos;

  localparam int ITERS = 16;
  localparam int GUARD = 2;
  localparam int F     = 22 + GUARD;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        clk_en = 1'b1;
  logic        start  = 1'b0;
  logic [23:0] angle  = 24'h0;
  logic        busy;
  logic        done;
  logic [23:0] result;
`ifdef CORDIC_SIN_EN
  logic [23:0] sin_out;
`endif

  always #5 clk = ~clk;

  cordic_cos #(.ITERS(ITERS), .GUARD(GUARD)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .angle  (angle),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef CORDIC_SIN_EN
    ,
    .sin_out(sin_out)
`endif
  );

  typedef struct {
    longint e_cyc;
    longint c;
    longint s;
  } exp_t;

  exp_t   q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  longint en_cycle = 0;
  longint cyc = 0;
  longint start_cyc = 0;
  logic   en_edge = 1'b0;
  bit     rand_en = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_edge <= clk_en && !reset;
    if (clk_en && !reset) en_cycle <= en_cycle + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp, input longint tol);
    n_chk++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic longint sgn24(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: rotation-mode CORDIC evaluated in plain integer/real arithmetic.
  function automatic exp_t model(input logic [23:0] a);
    exp_t   m;
    longint x, y, z, xn, lut;
    x = longint'($floor(0.6072529350 * (2.0 ** F) + 0.5));
    y = 0;
    z = sgn24(a) * (64'sd1 <<< GUARD);
    for (int i = 0; i < ITERS; i++) begin
      lut = longint'($floor($atan(2.0 ** (-i)) * (2.0 ** F) + 0.5));
      if (z >= 0) begin
        xn = x - (y >>> i); y = y + (x >>> i); z = z - lut;
      end else begin
        xn = x + (y >>> i); y = y - (x >>> i); z = z + lut;
      end
      x = xn;
    end
    m.c = x >>> GUARD;
    if (m.c > 4194304) m.c = 4194304;
    m.s = y >>> GUARD;
    if (m.s > 4194304) m.s = 4194304;
    if (m.s < -4194304) m.s = -4194304;
    m.e_cyc = 0;
    return m;
  endfunction

  exp_t   hd;
  logic   exp_busy;
  logic   at_done;

  // Scoreboard: every enabled, non-reset cycle checks busy/done and the result on done.
  always @(negedge clk) begin
    if (en_edge && !reset) begin
      exp_busy = 1'b0;
      at_done  = 1'b0;
      if (q.size() > 0) begin
        exp_busy = (en_cycle < q[0].e_cyc);
        at_done  = (en_cycle == q[0].e_cyc);
      end
      chk("busy", longint'(busy), longint'(exp_busy));
      chk("done", longint'(done), longint'(at_done));
      if (at_done) begin
        hd = q.pop_front();
        chk("result", sgn24(result), hd.c);
`ifdef CORDIC_SIN_EN
        chk("sin_out", sgn24(sin_out), hd.s);
`endif
      end else if (q.size() > 0) begin
        if (en_cycle > q[0].e_cyc) void'(q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) clk_en = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [23:0] a);
    exp_t m;
    angle = a;
    start = 1'b1;
    do begin
      @(posedge clk);
      #1;
    end while (!en_edge);
    start = 1'b0;
    m = model(a);
    m.e_cyc = en_cycle + ITERS;
    q.push_back(m);
    start_cyc = cyc;
  endtask

  task automatic wait_done();
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 400 && !ok) begin
      @(negedge clk);
      n++;
      if (done && en_edge && !reset) ok = 1'b1;
    end
    chk("done_seen", longint'(ok), 1);
  endtask

  exp_t pm;
  int   gap;
  int   ra;

  initial begin
    pm = model(24'h000000);
    chk_tol("model_cos0", pm.c, 4194304, 96);
    chk_tol("model_sin0", pm.s, 0, 96);
    pm = model(24'h400000);
    chk_tol("model_cos1", pm.c, 2266192, 96);
    chk_tol("model_sin1", pm.s, 3529385, 96);
    pm = model(24'hC00000);
    chk_tol("model_cosm1", pm.c, 2266192, 96);
    chk_tol("model_sinm1", pm.s, -3529385, 96);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_result", sgn24(result), 0);
    @(posedge clk); #1 reset = 1'b0;

    // angle 0, then 1.0, then -1.0 started on the DONE cycle
    issue(24'h000000);
    wait_done();
    chk("lat_0", cyc - start_cyc, 16);
    chk_tol("cos_0", sgn24(result), 4194304, 96);
    repeat (2) @(negedge clk);
    issue(24'h400000);
    wait_done();
    chk_tol("cos_1", sgn24(result), 2266192, 96);
`ifdef CORDIC_SIN_EN
    chk_tol("sin_1", sgn24(sin_out), 3529385, 96);
`endif
    issue(24'hC00000);
    wait_done();
    chk("lat_b2b", cyc - start_cyc, 16);
    chk_tol("cos_m1", sgn24(result), 2266192, 96);
`ifdef CORDIC_SIN_EN
    chk_tol("sin_m1", sgn24(sin_out), -3529385, 96);
`endif

    // start pulsed during RUN is ignored
    repeat (3) @(negedge clk);
    issue(24'h123456);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; angle = 24'h3FFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    chk("lat_midstart", cyc - start_cyc, 16);
    repeat (20) @(negedge clk);

    // reset at iteration 5 aborts
    issue(24'h200000);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_result", sgn24(result), 0);
    repeat (25) @(negedge clk);
    chk("abort_result_hold", sgn24(result), 0);
    issue(24'h3FFFFF);
    wait_done();
    chk("lat_after_abort", cyc - start_cyc, 16);

    // clk_en low for 3 cycles mid-RUN
    repeat (2) @(negedge clk);
    issue(24'hE00000);
    repeat (4) @(posedge clk);
    #1 clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 clk_en = 1'b1;
    wait_done();
    chk("lat_clken", cyc - start_cyc, 19);

    // randomized angles, gaps and clock-enable gating
    rand_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ra = int'($urandom_range(0, 8388607)) - 4194304;
      issue(24'(ra));
      wait_done();
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
    end
    @(negedge clk);
    rand_en = 1'b0;
    clk_en = 1'b1;
    repeat (30) @(negedge clk);
    chk("queue_empty", longint'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
